touch_led_sched: RTL

TOUCH_LED_SCHED -- requirements
Module: touch_led_sched

---
 rtl/touch_led_pkg.sv | 31 +++
 rtl/key_debounce.sv | 58 +++++
 rtl/touch_led_sched.sv | 118 +++++++++++
 3 files changed

// File: rtl/touch_led_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | touch_led_pkg                                                            |
// | Mode codes, LED patterns and mode sequencing for touch_led_sched.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package touch_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_RUN   = 2'd3
  } mode_e;

  // LEDs are active-low: a 0 bit lights the LED.
  localparam logic [3:0] LED_ALL_OFF = 4'b1111;
  localparam logic [3:0] LED_ALL_ON  = 4'b0000;
  localparam logic [3:0] RUN_START   = 4'b1110;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:   next_mode = MODE_ON;
      MODE_ON:    next_mode = MODE_BLINK;
      MODE_BLINK: next_mode = MODE_RUN;
      default:    next_mode = MODE_OFF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_debounce                                                             |
// | Two-flop synchroniser, stable-level debounce and press/release pulses.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module key_debounce #(
  parameter int unsigned CNT_DEB = 500000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_i,
  output logic press_o,
  output logic rel_o
);

  localparam int unsigned     DEB_W    = (CNT_DEB > 1) ? $clog2(CNT_DEB) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(CNT_DEB - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             key_state_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic             press_q;
  logic             rel_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      key_state_q <= 1'b0;
      deb_cnt_q   <= '0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the stability window.
      if (sync2_q == key_state_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        deb_cnt_q   <= '0;
        key_state_q <= sync2_q;
        press_q     <= sync2_q;
        rel_q       <= ~sync2_q;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;
  assign rel_o   = rel_q;

endmodule
`default_nettype wire

// File: rtl/touch_led_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | touch_led_sched                                                          |
// | Touch-key mode scheduler driving four active-low LEDs (OFF/ON/BLINK/RUN).|
// | Option macro TOUCH_LONG_PRESS_EN: a hold of CNT_LONG cycles forces OFF.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module touch_led_sched #(
  parameter int unsigned CNT_DEB   = 500000,
  parameter int unsigned CNT_LONG  = 50000000,
  parameter int unsigned CNT_BLINK = 12500000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       touch_key,
  output logic [3:0] led,
  output logic [1:0] mode
);

  import touch_led_pkg::*;

  localparam int unsigned      STEP_W    = (CNT_BLINK > 1) ? $clog2(CNT_BLINK) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CNT_BLINK - 1);

  if (CNT_DEB < 1 || CNT_LONG < 2 || CNT_BLINK < 2) begin : g_cfg_check
    $error("touch_led_sched: count parameters out of range");
  end

  logic              press_pulse;
  logic              rel_pulse;
  logic              long_hit;
  mode_e             mode_q;
  logic              armed_q;
  logic              chg_q;
  logic [STEP_W-1:0] step_q;
  logic [3:0]        led_q;

  key_debounce #(
    .CNT_DEB (CNT_DEB)
  ) u_debounce (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_i     (touch_key),
    .press_o   (press_pulse),
    .rel_o     (rel_pulse)
  );

`ifdef TOUCH_LONG_PRESS_EN
  localparam int unsigned     DUR_W    = $clog2(CNT_LONG + 1);
  localparam logic [DUR_W-1:0] DUR_MAX  = DUR_W'(CNT_LONG);
  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(CNT_LONG - 1);

  logic [DUR_W-1:0] dur_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dur_q <= '0;
    end else if (press_pulse) begin
      dur_q <= '0;
    end else if (armed_q && dur_q != DUR_MAX) begin
      dur_q <= dur_q + 1'b1;
    end
  end

  // armed_q drops when this fires, so it triggers once per press.
  assign long_hit = armed_q && (dur_q == DUR_LAST);
`else
  assign long_hit = 1'b0;
`endif

  // armed_q tracks a press that may still advance the mode on release.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q  <= MODE_OFF;
      armed_q <= 1'b0;
      chg_q   <= 1'b0;
      step_q  <= '0;
      led_q   <= LED_ALL_OFF;
    end else begin
      chg_q <= 1'b0;
      if (press_pulse) begin
        armed_q <= 1'b1;
      end
      if (long_hit) begin
        mode_q  <= MODE_OFF;
        armed_q <= 1'b0;
        chg_q   <= 1'b1;
      end else if (rel_pulse) begin
        armed_q <= 1'b0;
        if (armed_q) begin
          mode_q <= next_mode(mode_q);
          chg_q  <= 1'b1;
        end
      end

      if (chg_q) begin
        step_q <= '0;
        case (mode_q)
          MODE_ON, MODE_BLINK: led_q <= LED_ALL_ON;
          MODE_RUN:            led_q <= RUN_START;
          default:             led_q <= LED_ALL_OFF;
        endcase
      end else if (mode_q == MODE_BLINK || mode_q == MODE_RUN) begin
        if (step_q == STEP_LAST) begin
          step_q <= '0;
          led_q  <= (mode_q == MODE_BLINK) ? ~led_q : {led_q[2:0], led_q[3]};
        end else begin
          step_q <= step_q + 1'b1;
        end
      end
    end
  end

  assign mode = mode_q;
  assign led  = led_q;

endmodule
`default_nettype wire
